sef_pipe: RTL and testbench



---
 rtl/t2t_pkg.sv | 4 +
 rtl/tts_pkg.sv | 4 +
 rtl/sef_pipe_if.sv | 28 ++
 rtl/sat_counter.sv | 14 +
 rtl/sef_pipe.sv | 117 +++++++++++
 tb/tb_sef_pipe.sv | 232 +++++++++++++++++++++++
 6 files changed

// File: rtl/t2t_pkg.sv
// t2t_pkg: feed message-type constants shared with the decoder
package t2t_pkg;
  localparam logic [63:0] MSG_NEW = 64'h0000_0000_004e_4557;
endpackage

// File: rtl/tts_pkg.sv
// tts_pkg: strategy execution FSM state encoding
package tts_pkg;
  typedef enum logic [2:0] {IDLE, LOOKUP, BEAT, CMP, RES, OUT} t_sefp_st;
endpackage

// File: rtl/sef_pipe_if.sv
// sef_pipe_if: decoder beats, RCB/comparator strobes and order handshake of sef_pipe
interface sef_pipe_if #(parameter int DATA_W = 64);
  logic              dec_valid;
  logic              dec_sop;
  logic [DATA_W-1:0] dec_data;
  logic              tts_sym_vld;
  logic              cmp_hit;
  logic              sef_rd_srcb;
  logic              sef_pcmp_load_a;
  logic              sef_rd_prcb;
  logic              sef_rd_vrcb;
  logic              sef_rd_orcb;
  logic              sef_pcmp_load_b;
  logic              sef_vcmp_load_a;
  logic              sef_vcmp_load_b;
  logic              ord_valid;
  logic              ord_ready;
  modport master (
    output dec_valid, dec_sop, dec_data, tts_sym_vld, cmp_hit, ord_ready,
    input  sef_rd_srcb, sef_pcmp_load_a, sef_rd_prcb, sef_rd_vrcb, sef_rd_orcb,
           sef_pcmp_load_b, sef_vcmp_load_a, sef_vcmp_load_b, ord_valid
  );
  modport slave (
    input  dec_valid, dec_sop, dec_data, tts_sym_vld, cmp_hit, ord_ready,
    output sef_rd_srcb, sef_pcmp_load_a, sef_rd_prcb, sef_rd_vrcb, sef_rd_orcb,
           sef_pcmp_load_b, sef_vcmp_load_a, sef_vcmp_load_b, ord_valid
  );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that holds at all-ones instead of wrapping
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);
  // count events until saturated
  always_ff @(posedge clk)
    if (reset) count <= '0;
    else if (inc && !(&count)) count <= count + W'(1);
endmodule

// File: rtl/sef_pipe.sv
// sef_pipe: strategy execution FSM sequencing RCB reads, comparator loads and order issue
module sef_pipe
  import t2t_pkg::*;
  import tts_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int TYPE_MSB = 63,
  parameter int TYPE_LSB = 40,
  parameter int RAM_LAT  = 1,
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  sef_pipe_if.slave        bus,
  output logic             busy,
  output logic [CNT_W-1:0] cnt_fired,
  output logic [CNT_W-1:0] cnt_nohit,
  output logic [CNT_W-1:0] cnt_abort_sym,
  output logic [CNT_W-1:0] cnt_abort_beat,
  output logic [CNT_W-1:0] cnt_drop
);
  localparam int CW = $clog2(RAM_LAT > TIMEOUT ? RAM_LAT : TIMEOUT) + 1;
  localparam int TW = TYPE_MSB - TYPE_LSB + 1;
  localparam logic [CW-1:0] LAT_LAST = CW'(RAM_LAT - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  t_sefp_st st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [DATA_W-1:0] data;
  logic beat_pend, beat_pend_n, new_msg, beat, trig, last, unused_data;
  logic inc_fired, inc_nohit, inc_asym, inc_abeat, inc_drop;
  assign data        = bus.dec_data;
  assign unused_data = ^data;
  assign new_msg     = bus.dec_valid & bus.dec_sop & (data[TYPE_MSB:TYPE_LSB] == MSG_NEW[TW-1:0]);
  assign beat        = bus.dec_valid & ~bus.dec_sop;
  assign trig        = beat_pend | beat;
  assign last        = cnt == LAT_LAST;
  assign busy        = st != IDLE;
  // state, latency/timeout count and early second-beat flag
  always_ff @(posedge clk)
    if (reset) begin
      st        <= IDLE;
      cnt       <= '0;
      beat_pend <= 1'b0;
    end else begin
      st        <= st_n;
      cnt       <= cnt_n;
      beat_pend <= beat_pend_n;
    end
  // next state, one-cycle strobes and statistics events
  always_comb begin
    st_n                = st;
    cnt_n               = cnt + CW'(1);
    beat_pend_n         = (st == LOOKUP) & trig;
    bus.sef_rd_srcb     = 1'b0;
    bus.sef_pcmp_load_a = 1'b0;
    bus.sef_rd_prcb     = 1'b0;
    bus.sef_rd_vrcb     = 1'b0;
    bus.sef_rd_orcb     = 1'b0;
    bus.sef_pcmp_load_b = 1'b0;
    bus.sef_vcmp_load_a = 1'b0;
    bus.sef_vcmp_load_b = 1'b0;
    bus.ord_valid       = 1'b0;
    inc_fired           = 1'b0;
    inc_nohit           = 1'b0;
    inc_asym            = 1'b0;
    inc_abeat           = 1'b0;
    inc_drop            = new_msg & (st != IDLE);
    case (st)
      IDLE: begin
        cnt_n = '0;
        if (new_msg & enable) begin
          bus.sef_rd_srcb     = 1'b1;
          bus.sef_pcmp_load_a = 1'b1;
          st_n                = LOOKUP;
        end
      end
      LOOKUP: if (last) begin
        cnt_n    = '0;
        st_n     = bus.tts_sym_vld ? BEAT : IDLE;
        inc_asym = ~bus.tts_sym_vld;
      end
      BEAT: if (trig) begin
        bus.sef_rd_prcb     = 1'b1;
        bus.sef_rd_vrcb     = 1'b1;
        bus.sef_rd_orcb     = 1'b1;
        bus.sef_pcmp_load_b = 1'b1;
        bus.sef_vcmp_load_a = 1'b1;
        cnt_n               = '0;
        st_n                = CMP;
      end else if ((bus.dec_valid & bus.dec_sop) | (cnt == TO_LAST)) begin
        st_n      = IDLE;
        inc_abeat = 1'b1;
      end
      CMP: if (last) begin
        bus.sef_vcmp_load_b = 1'b1;
        st_n                = RES;
      end
      RES: begin
        st_n      = bus.cmp_hit ? OUT : IDLE;
        inc_nohit = ~bus.cmp_hit;
      end
      OUT: begin
        bus.ord_valid = 1'b1;
        st_n          = bus.ord_ready ? IDLE : OUT;
        inc_fired     = bus.ord_ready;
      end
      default: st_n = IDLE;
    endcase
  end
  sat_counter #(.W(CNT_W)) u_fired (.clk(clk), .reset(reset), .inc(inc_fired), .count(cnt_fired));
  sat_counter #(.W(CNT_W)) u_nohit (.clk(clk), .reset(reset), .inc(inc_nohit), .count(cnt_nohit));
  sat_counter #(.W(CNT_W)) u_asym  (.clk(clk), .reset(reset), .inc(inc_asym),  .count(cnt_abort_sym));
  sat_counter #(.W(CNT_W)) u_abeat (.clk(clk), .reset(reset), .inc(inc_abeat), .count(cnt_abort_beat));
  sat_counter #(.W(CNT_W)) u_drop  (.clk(clk), .reset(reset), .inc(inc_drop),  .count(cnt_drop));
endmodule

// File: tb/tb_sef_pipe.sv
// tb_sef_pipe: vector table, directed corner sequences and randomized timeline-model checks of sef_pipe
module tb_sef_pipe;
  import t2t_pkg::*;
  localparam int L = 2, TO = 4, CW = 4;
  localparam int CMAX = (1 << CW) - 1;
  typedef struct {
    bit [6:0] in;
    bit [4:0] ex;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, busy;
  logic [CW-1:0] cnt_fired, cnt_nohit, cnt_abort_sym, cnt_abort_beat, cnt_drop;
  int n_run = 0, n_fail = 0;
  bit m_busy, m_pend, m_bt, e_srcb, e_beat, e_lb, e_ov, m_start, m_fin, m_trig;
  bit [4:0] m_inc;
  int m_k = 0, m_tb = -1;
  int unsigned m_cnt [5];
  sef_pipe_if #(.DATA_W(64)) bus ();
  sef_pipe #(.DATA_W(64), .TYPE_MSB(63), .TYPE_LSB(40), .RAM_LAT(L), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .bus(bus), .busy(busy),
    .cnt_fired(cnt_fired), .cnt_nohit(cnt_nohit), .cnt_abort_sym(cnt_abort_sym),
    .cnt_abort_beat(cnt_abort_beat), .cnt_drop(cnt_drop)
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int req);
    n_run++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d at %0t", nm, act, req, $time);
    end
  endtask
  function automatic bit is_new();
    logic [63:0] d, mn;
    d  = bus.dec_data;
    mn = MSG_NEW;
    return bus.dec_valid & bus.dec_sop & (d[63:40] == mn[23:0]);
  endfunction
  // Timeline model: k counts cycles since acceptance, tb records the cycle the second beat fired.
  function automatic void model_eval();
    bit nm;
    nm = is_new();
    m_bt = bus.dec_valid & !bus.dec_sop;
    {e_srcb, e_beat, e_lb, e_ov, m_start, m_fin, m_trig} = '0;
    m_inc = '0;
    if (!m_busy) begin
      e_srcb  = nm & enable;
      m_start = e_srcb;
    end else begin
      m_inc[4] = nm;
      if (m_tb < 0 && m_k <= L) begin
        if (m_k == L && !bus.tts_sym_vld) begin m_inc[2] = 1; m_fin = 1; end
      end else if (m_tb < 0) begin
        if (m_pend | m_bt) begin e_beat = 1; m_trig = 1; end
        else if ((bus.dec_valid & bus.dec_sop) || (m_k - L - 1 == TO - 1)) begin m_inc[3] = 1; m_fin = 1; end
      end else if (m_k - m_tb <= L) e_lb = (m_k - m_tb == L);
      else if (m_k - m_tb == L + 1) begin m_inc[1] = !bus.cmp_hit; m_fin = !bus.cmp_hit; end
      else begin e_ov = 1; m_inc[0] = bus.ord_ready; m_fin = bus.ord_ready; end
    end
  endfunction
  function automatic void model_commit(bit rst);
    if (rst) begin
      m_busy = 0; m_pend = 0; m_k = 0; m_tb = -1;
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      return;
    end
    for (int i = 0; i < 5; i++) if (m_inc[i] && m_cnt[i] < CMAX) m_cnt[i]++;
    if (m_start) begin m_busy = 1; m_k = 1; m_tb = -1; m_pend = 0; end
    else if (m_fin) m_busy = 0;
    else if (m_busy) begin
      if (m_tb < 0 && m_k <= L && m_bt) m_pend = 1;
      if (m_trig) m_tb = m_k;
      m_k++;
    end
  endfunction
  task automatic drive(bit en, bit v, bit s, bit nw, bit sym, bit hit, bit rdy);
    logic [63:0] d, mn;
    mn = MSG_NEW;
    d  = {$urandom, $urandom};
    if (nw) d[63:40] = mn[23:0];
    else if (d[63:40] == mn[23:0]) d[40] = ~d[40];
    enable          = en;
    bus.dec_valid   = v;
    bus.dec_sop     = s;
    bus.dec_data    = d;
    bus.tts_sym_vld = sym;
    bus.cmp_hit     = hit;
    bus.ord_ready   = rdy;
  endtask
  task automatic tick();
    #1;
    model_eval();
    chk("srcb", bus.sef_rd_srcb, e_srcb);
    chk("pcmp_load_a", bus.sef_pcmp_load_a, e_srcb);
    chk("prcb", bus.sef_rd_prcb, e_beat);
    chk("vrcb", bus.sef_rd_vrcb, e_beat);
    chk("orcb", bus.sef_rd_orcb, e_beat);
    chk("pcmp_load_b", bus.sef_pcmp_load_b, e_beat);
    chk("vcmp_load_a", bus.sef_vcmp_load_a, e_beat);
    chk("vcmp_load_b", bus.sef_vcmp_load_b, e_lb);
    chk("ord_valid", bus.ord_valid, e_ov);
    chk("busy", busy, m_busy);
    @(posedge clk);
    model_commit(reset);
    #1;
    chk("cnt_fired", cnt_fired, m_cnt[0]);
    chk("cnt_nohit", cnt_nohit, m_cnt[1]);
    chk("cnt_abort_sym", cnt_abort_sym, m_cnt[2]);
    chk("cnt_abort_beat", cnt_abort_beat, m_cnt[3]);
    chk("cnt_drop", cnt_drop, m_cnt[4]);
    @(negedge clk);
  endtask
  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0);
    reset = 1;
    repeat (2) @(posedge clk);
    model_commit(1);
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_ord_valid", bus.ord_valid, 0);
    chk("rst_srcb", bus.sef_rd_srcb, 0);
    chk("rst_cnt_fired", cnt_fired, 0);
    chk("rst_cnt_drop", cnt_drop, 0);
  endtask
  task automatic msg(bit hit, int rdy_wait, int inj_at, output int nov);
    int w;
    w   = 0;
    nov = 0;
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 40 && busy; i++) begin
      drive(1, i == inj_at, i == inj_at, 1, 1, hit, bus.ord_valid && w >= rdy_wait);
      if (bus.ord_valid) begin nov++; w++; end
      tick();
    end
    chk("msg_done", busy, 0);
  endtask
  initial begin
    vec_t tab [13];
    int nov;
    tab = '{
      '{7'b1111001, 5'b10000}, '{7'b1100001, 5'b00001}, '{7'b1000101, 5'b00001},
      '{7'b1000101, 5'b01001}, '{7'b1000001, 5'b00001}, '{7'b1000001, 5'b00101},
      '{7'b1000011, 5'b00001}, '{7'b1000001, 5'b00011}, '{7'b1000001, 5'b00000},
      '{7'b1111001, 5'b10000}, '{7'b1100001, 5'b00001}, '{7'b1000001, 5'b00001},
      '{7'b1000101, 5'b00000}
    };
    drive(1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    foreach (tab[i]) begin
      drive(tab[i].in[6], tab[i].in[5], tab[i].in[4], tab[i].in[3], tab[i].in[2], tab[i].in[1], tab[i].in[0]);
      #1;
      chk("tab_srcb", bus.sef_rd_srcb, tab[i].ex[4]);
      chk("tab_prcb", bus.sef_rd_prcb, tab[i].ex[3]);
      chk("tab_vcmp_load_b", bus.sef_vcmp_load_b, tab[i].ex[2]);
      chk("tab_ord_valid", bus.ord_valid, tab[i].ex[1]);
      chk("tab_busy", busy, tab[i].ex[0]);
      tick();
    end
    chk("tab_fired", cnt_fired, 1);
    chk("tab_abort_sym", cnt_abort_sym, 1);
    do_reset();
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    repeat (TO) begin
      chk("to_busy", busy, 1);
      drive(1, 0, 0, 0, 1, 0, 0);
      tick();
    end
    chk("to_idle", busy, 0);
    chk("to_abort_beat", cnt_abort_beat, 1);
    do_reset();
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    drive(1, 1, 1, 1, 1, 1, 1); tick();
    chk("sop_idle", busy, 0);
    chk("sop_abort_beat", cnt_abort_beat, 1);
    chk("sop_drop", cnt_drop, 1);
    do_reset();
    msg(0, 0, -1, nov);
    chk("nohit_ov_cycles", nov, 0);
    chk("nohit_cnt", cnt_nohit, 1);
    do_reset();
    msg(1, 10, -1, nov);
    chk("bp_ov_cycles", nov, 11);
    chk("bp_fired", cnt_fired, 1);
    do_reset();
    msg(1, 0, 1, nov);
    chk("cmpdrop_ov_cycles", nov, 1);
    chk("cmpdrop_drop", cnt_drop, 1);
    chk("cmpdrop_fired", cnt_fired, 1);
    do_reset();
    drive(0, 1, 1, 1, 1, 1, 1);
    #1;
    chk("en0_srcb", bus.sef_rd_srcb, 0);
    tick();
    chk("en0_busy", busy, 0);
    chk("en0_drop", cnt_drop, 0);
    do_reset();
    repeat (17) msg(1, 0, -1, nov);
    chk("sat_fired", cnt_fired, CMAX);
    drive(1, 1, 1, 1, 0, 0, 0); tick();
    drive(1, 1, 0, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 0, 1, 0, 0); tick();
    for (int i = 0; i < 10 && !bus.ord_valid; i++) begin
      drive(1, 0, 0, 0, 1, 1, 0);
      tick();
    end
    chk("rst_out_pre_ov", bus.ord_valid, 1);
    reset = 1;
    drive(1, 0, 0, 0, 1, 1, 0);
    tick();
    reset = 0;
    chk("rst_out_ov", bus.ord_valid, 0);
    chk("rst_out_busy", busy, 0);
    chk("rst_out_fired", cnt_fired, 0);
    for (int c = 0; c < 6000; c++) begin
      reset = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 7) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
            $urandom_range(0, 2) != 0);
      tick();
    end
    reset = 0;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
